// File: rtl/riscv_pkg.sv
// Shared definitions for the core's memory-side blocks.
//   XLEN         : native word width
//   NOP_INSN     : canonical RISC-V NOP (addi x0, x0, 0), returned on a faulted fetch
//   imem_state_t : control states of the instruction-memory responder
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_RESET,
    IMEM_IDLE,
    IMEM_LOAD
  } imem_state_t;

endpackage

// File: rtl/resp_pipe.sv
// Fixed-depth response delay line carrying {valid, err, data}.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-low clear (valid bits only)
//   in_valid_i    : a response enters stage 0 on this edge
//   in_err_i/data : payload travelling with the valid bit
//   out_valid_o   : valid bit leaving the last stage
//   out_err_o/data: payload of the last stage; holds between responses
//   busy_o        : any stage holds a valid response
module resp_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic             in_err_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic             out_err_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             busy_o
);

  logic [LATENCY-1:0] valid_d, valid_q;
  logic [LATENCY-1:0] err_d, err_q;
  logic [WIDTH-1:0]   data_d [LATENCY];
  logic [WIDTH-1:0]   data_q [LATENCY];

  // Payload of a stage only moves when a valid response moves into it, so the
  // last stage keeps presenting the previous response between valids.
  always_comb begin
    valid_d = '0;
    err_d   = err_q;
    data_d  = data_q;
    valid_d[0] = in_valid_i;
    if (in_valid_i) begin
      err_d[0]  = in_err_i;
      data_d[0] = in_data_i;
    end
    for (int k = 1; k < LATENCY; k++) begin
      valid_d[k] = valid_q[k-1];
      if (valid_q[k-1]) begin
        err_d[k]  = err_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    err_q  <= err_d;
    data_q <= data_d;
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_err_o   = err_q[LATENCY-1];
  assign out_data_o  = data_q[LATENCY-1];
  assign busy_o      = |valid_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: memory end of the core fetch path.
// Serves one word fetch per cycle with a fixed pipelined latency and offers a
// loader write port for programming the array.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-low reset
//   req_i, addr_i   : fetch request and byte address; accepted when req_i && ready_o
//   ready_o         : a fetch can be accepted this cycle
//   rvalid_o        : one-cycle response strobe per accepted fetch
//   rdata_o, err_o  : response word (NOP on error) and error flag, qualified by rvalid_o
//   load_en_i       : loader owns the memory, fetches refused
//   load_we_i       : loader write strobe (only with load_en_i)
//   load_addr_i     : loader word index
//   load_data_i     : loader write data
//   busy_o          : at least one response in flight
module imem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic [XLEN-1:0]          addr_i,
  output logic                     ready_o,
  output logic                     rvalid_o,
  output logic [XLEN-1:0]          rdata_o,
  output logic                     err_o,
  input  logic                     load_en_i,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [XLEN-1:0]          load_data_i,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);

  imem_state_t state_d, state_q;
  logic        seen_d, seen_q;

  logic [XLEN-1:0] mem_q [DEPTH];

  logic [AW-1:0]   fetch_idx;
  logic            fetch_err;
  logic            accept;
  logic [XLEN-1:0] fetch_data;

  logic            pipe_valid;
  logic            pipe_err;
  logic [XLEN-1:0] pipe_data;

  // Control FSM: one settling cycle after reset, then IDLE/LOAD follow load_en_i.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IMEM_RESET: state_d = IMEM_IDLE;
      IMEM_IDLE:  if (load_en_i) state_d = IMEM_LOAD;
      IMEM_LOAD:  if (!load_en_i) state_d = IMEM_IDLE;
      default:    state_d = IMEM_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IMEM_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign ready_o = (state_q == IMEM_IDLE);
  assign accept  = req_i && ready_o;

  // Misaligned, or any address bit above the array's word range, is a fault.
  always_comb begin
    fetch_idx  = addr_i[2 +: AW];
    fetch_err  = (addr_i[1:0] != 2'b00) || (addr_i[XLEN-1:2+AW] != '0);
    fetch_data = fetch_err ? NOP_INSN : mem_q[fetch_idx];
  end

  // Program storage; not reset so a loaded image survives a core reset.
  always_ff @(posedge clk) begin
    if (load_en_i && load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  resp_pipe #(
    .LATENCY (LATENCY),
    .WIDTH   (XLEN)
  ) u_resp_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (accept),
    .in_err_i    (fetch_err),
    .in_data_i   (fetch_data),
    .out_valid_o (pipe_valid),
    .out_err_o   (pipe_err),
    .out_data_o  (pipe_data),
    .busy_o      (busy_o)
  );

  // The pipe's payload is not reset; outputs read as zero until the first
  // response after reset has left the pipe, then hold the last response.
  always_comb begin
    seen_d = seen_q | pipe_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign rvalid_o = pipe_valid;
  assign rdata_o  = seen_d ? pipe_data : '0;
  assign err_o    = seen_d ? pipe_err : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder. Three instances (LATENCY 1, 3, 4)
// share one stimulus stream; a scoreboard queue per instance holds expected
// responses, pushed when a fetch is accepted and popped on rvalid_o.
module tb_imem_responder;
  import riscv_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    int          acc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [31:0]   addr;
  logic          load_en;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;

  logic          ready  [3];
  logic          rvalid [3];
  logic [31:0]   rdata  [3];
  logic          errs   [3];
  logic          busy   [3];

  exp_t          q0[$];
  exp_t          q1[$];
  exp_t          q2[$];
  logic [31:0]   memModel [DEPTH];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            st = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instances differ only in response latency.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req),
      .addr_i      (addr),
      .ready_o     (ready[g]),
      .rvalid_o    (rvalid[g]),
      .rdata_o     (rdata[g]),
      .err_o       (errs[g]),
      .load_en_i   (load_en),
      .load_we_i   (load_we),
      .load_addr_i (load_addr),
      .load_data_i (load_data),
      .busy_o      (busy[g])
    );
  end

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Compares one popped scoreboard entry against the response on the bus.
  task automatic checkResp(input string name, input int lat, input exp_t e,
                           input logic [31:0] rd, input logic er);
    checkOutput({name, "_cycle"}, cyc, e.acc + lat - 1);
    checkOutput({name, "_rdata"}, rd, e.data);
    checkOutput({name, "_err"}, {31'd0, er}, {31'd0, e.err});
  endtask

  // Drives one cycle of inputs, checks ready/busy, and scores accepted fetches
  // using the bench's own state and memory model.
  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic le,
                               input logic lw, input logic [AW-1:0] la, input logic [31:0] ld);
    logic rdy;
    exp_t e;
    req = r; addr = a; load_en = le; load_we = lw; load_addr = la; load_data = ld;
    rdy = (st == 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("ready%0d", i), {31'd0, ready[i]}, {31'd0, rdy});
    end
    checkOutput("busyL1", {31'd0, busy[0]}, {31'd0, (q0.size() > 0 && q0[0].acc <= cyc)});
    checkOutput("busyL3", {31'd0, busy[1]}, {31'd0, (q1.size() > 0 && q1[0].acc <= cyc)});
    checkOutput("busyL4", {31'd0, busy[2]}, {31'd0, (q2.size() > 0 && q2[0].acc <= cyc)});
    if (r && rdy) begin
      e.acc  = cyc + 1;
      e.err  = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
      e.data = e.err ? 32'h0000_0013 : memModel[a[AW+1:2]];
      q0.push_back(e);
      q1.push_back(e);
      q2.push_back(e);
    end
    if (le && lw) memModel[la] = ld;
    if (st == 0) st = 1;
    else st = le ? 2 : 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
  endtask

  // Asserts reset (discarding anything in flight), checks reset outputs, releases it.
  task automatic doReset();
    rst = 1'b0;
    req = 1'b0; addr = '0; load_en = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    q0.delete();
    q1.delete();
    q2.delete();
    st = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_rvalid%0d", i), {31'd0, rvalid[i]}, 32'd0);
      checkOutput($sformatf("rst_ready%0d", i), {31'd0, ready[i]}, 32'd0);
      checkOutput($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
      checkOutput($sformatf("rst_err%0d", i), {31'd0, errs[i]}, 32'd0);
      checkOutput($sformatf("rst_busy%0d", i), {31'd0, busy[i]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Response monitor: every rvalid_o must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst) begin
      if (rvalid[0]) begin
        if (q0.size() == 0) checkOutput("spuriousL1", {31'd0, rvalid[0]}, 32'd0);
        else checkResp("L1", 1, q0.pop_front(), rdata[0], errs[0]);
      end
      if (rvalid[1]) begin
        if (q1.size() == 0) checkOutput("spuriousL3", {31'd0, rvalid[1]}, 32'd0);
        else checkResp("L3", 3, q1.pop_front(), rdata[1], errs[1]);
      end
      if (rvalid[2]) begin
        if (q2.size() == 0) checkOutput("spuriousL4", {31'd0, rvalid[2]}, 32'd0);
        else checkResp("L4", 4, q2.pop_front(), rdata[2], errs[2]);
      end
    end
  end

  initial begin
    doReset();
    // First cycle after release: ready low; afterwards IDLE.
    idleCycles(1);

    // Program a few words through the loader.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 8'd0, 32'h0050_0093);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 8'd1, 32'h00a0_0113);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 8'd2, 32'h00f0_0193);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 8'd5, 32'h1111_1111);
    idleCycles(2);

    // Single fetch, then back-to-back fetches.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    idleCycles(5);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, '0, 32'h0);
    idleCycles(6);

    // Faulting addresses: misaligned, one past the array, far out of range.
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1'b1, 32'(4 * DEPTH), 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1'b1, 32'(4 * DEPTH - 4), 1'b0, 1'b1, '0, 32'h0);
    idleCycles(6);

    // Same-edge fetch and load entry: fetch returns the pre-write word.
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b1, 8'd5, 32'h2222_2222);
    // LOAD: requests held high are refused while the earlier fetch drains.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, '0, 32'h0);
    // Leave LOAD with a stray write strobe that must be ignored.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 8'd5, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, '0, 32'h0);
    idleCycles(6);

    // Reset with two fetches in flight: they must never respond.
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, '0, 32'h0);
    doReset();
    idleCycles(6);
    // Array contents survive reset.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, '0, 32'h0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, '0, 32'h0);
    idleCycles(8);

    checkOutput("drainL1", q0.size(), 32'd0);
    checkOutput("drainL3", q1.size(), 32'd0);
    checkOutput("drainL4", q2.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
